npc_unit: RTL and testbench

Next-PC generator and redirect controller that drives the fetch-stage PC register of the pipelined CPU. Each cycle it computes the address the PC loads on the next clock edge and the PC load enable. It buffers branch/jump redirects that arrive during a pipeline stall and applies exception and ERET redirects with priority. It sits between the hazard, decode, and CP0 logic and the PC register, whose `nextPCounter` and `PC_EN` it feeds.

---
 rtl/npc_unit_if.sv | 26 ++
 rtl/npc_unit.sv | 92 +++++++++
 tb/tb_npc_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/npc_unit_if.sv
// Signal bundle between the pipeline control logic (hazard/decode/CP0) and the
// next-PC generator that feeds the fetch-stage PC register.
interface npc_unit_if;
  logic [31:0] pc_in;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        flush;
  logic        pending;
  logic        misalign;

  modport master (
    output pc_in, stall, redir_valid, redir_target, exc_req, eret_req, epc,
    input  next_pc, pc_en, flush, pending, misalign
  );

  modport slave (
    input  pc_in, stall, redir_valid, redir_target, exc_req, eret_req, epc,
    output next_pc, pc_en, flush, pending, misalign
  );
endinterface

// File: rtl/npc_unit.sv
// Next-PC generator: picks the PC register's next value and load enable, holds
// branch/jump redirects across stalls, and gives exception/ERET top priority.
module npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input logic       clk,
  input logic       reset,
  npc_unit_if.slave bus
);

  typedef enum logic {RUN, PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] target;
  logic        nonseq;
  logic        load_en;
  logic        do_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values; the async clear also empties a pending
  // redirect without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // NOTE: every variable gets a default before the priority chain, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    target        = bus.pc_in + 32'd4;
    nonseq        = 1'b0;
    load_en       = 1'b1;
    do_flush      = 1'b0;

    if (bus.exc_req) begin
      target        = EXC_VEC;
      nonseq        = 1'b1;
      do_flush      = 1'b1;
      state_d       = RUN;
      pend_target_d = '0;
    end else if (bus.eret_req) begin
      target        = bus.epc;
      nonseq        = 1'b1;
      do_flush      = 1'b1;
      state_d       = RUN;
      pend_target_d = '0;
    end else if (bus.stall) begin
      target  = bus.pc_in;
      load_en = 1'b0;
      if (bus.redir_valid) begin
        pend_target_d = bus.redir_target;
        state_d       = PEND;
      end
    end else if (bus.redir_valid) begin
      // A fresh redirect supersedes anything still buffered.
      target  = bus.redir_target;
      nonseq  = 1'b1;
      state_d = RUN;
    end else if (state_q == PEND) begin
      target  = pend_target_q;
      nonseq  = 1'b1;
      state_d = RUN;
    end
  end

  // Outputs are gated by reset directly so they settle the moment reset drops.
  always_comb begin
    if (!reset) begin
      bus.next_pc  = RESET_PC;
      bus.pc_en    = 1'b0;
      bus.flush    = 1'b0;
      bus.pending  = 1'b0;
      bus.misalign = 1'b0;
    end else begin
      bus.next_pc  = {target[31:2], 2'b00};
      bus.pc_en    = load_en;
      bus.flush    = do_flush;
      bus.pending  = (state_q == PEND);
      bus.misalign = nonseq & (|target[1:0]);
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: a table of per-cycle vectors plus a hand-written
// async-reset-during-PEND sequence.
module tb_npc_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  npc_unit_if bus ();

  npc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] e_npc;
    logic        e_en;
    logic        e_fl;
    logic        e_pend;
    logic        e_mis;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [31:0] pc, logic stall, logic rv, logic [31:0] rt,
                              logic exc, logic eret, logic [31:0] epc,
                              logic [31:0] e_npc, logic e_en, logic e_fl,
                              logic e_pend, logic e_mis);
    vec_t v;
    v.pc = pc; v.stall = stall; v.rv = rv; v.rt = rt;
    v.exc = exc; v.eret = eret; v.epc = epc;
    v.e_npc = e_npc; v.e_en = e_en; v.e_fl = e_fl; v.e_pend = e_pend; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic stall, input logic rv,
                       input logic [31:0] rt, input logic exc, input logic eret,
                       input logic [31:0] epc);
    bus.pc_in        = pc;
    bus.stall        = stall;
    bus.redir_valid  = rv;
    bus.redir_target = rt;
    bus.exc_req      = exc;
    bus.eret_req     = eret;
    bus.epc          = epc;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] npc, input logic en,
                            input logic fl, input logic pend, input logic mis);
    check({tag, " next_pc"},  bus.next_pc,          npc);
    check({tag, " pc_en"},    {31'b0, bus.pc_en},    {31'b0, en});
    check({tag, " flush"},    {31'b0, bus.flush},    {31'b0, fl});
    check({tag, " pending"},  {31'b0, bus.pending},  {31'b0, pend});
    check({tag, " misalign"}, {31'b0, bus.misalign}, {31'b0, mis});
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //              pc            st rv rt            ex er epc           npc           en fl pd ms
    vecs[0]  = mk(32'h0000_3000, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 1, 0, 0, 0);
    vecs[1]  = mk(32'h0000_3004, 1, 1, 32'h3040,     0, 0, 32'h0,        32'h0000_3004, 0, 0, 0, 0);
    vecs[2]  = mk(32'h0000_3004, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, 1, 0);
    vecs[3]  = mk(32'h0000_3004, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, 1, 0);
    vecs[4]  = mk(32'h0000_3004, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3040, 1, 0, 1, 0);
    vecs[5]  = mk(32'h0000_3040, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3044, 1, 0, 0, 0);
    vecs[6]  = mk(32'h0000_3044, 1, 1, 32'h3040,     0, 0, 32'h0,        32'h0000_3044, 0, 0, 0, 0);
    vecs[7]  = mk(32'h0000_3044, 1, 1, 32'h3080,     0, 0, 32'h0,        32'h0000_3044, 0, 0, 1, 0);
    vecs[8]  = mk(32'h0000_3044, 0, 1, 32'h30C0,     0, 0, 32'h0,        32'h0000_30C0, 1, 0, 1, 0);
    vecs[9]  = mk(32'h0000_30C0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_30C4, 1, 0, 0, 0);
    vecs[10] = mk(32'h0000_30C4, 1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_30C4, 0, 0, 0, 0);
    vecs[11] = mk(32'h0000_30C4, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 1, 1, 1, 0);
    vecs[12] = mk(32'h0000_4180, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, 1, 0, 0, 0);
    vecs[13] = mk(32'h0000_4184, 0, 0, 32'h0,        1, 1, 32'h3010,     32'h0000_4180, 1, 1, 0, 0);
    vecs[14] = mk(32'h0000_4180, 0, 0, 32'h0,        0, 1, 32'h3012,     32'h0000_3010, 1, 1, 0, 1);
    vecs[15] = mk(32'hFFFF_FFFC, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 0);
    vecs[16] = mk(32'h0000_0000, 0, 1, 32'h3002,     0, 0, 32'h0,        32'h0000_3000, 1, 0, 0, 1);
    vecs[17] = mk(32'h0000_3000, 1, 1, 32'h3006,     0, 0, 32'h0,        32'h0000_3000, 0, 0, 0, 0);
    vecs[18] = mk(32'h0000_3000, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 1, 0, 1, 1);
    vecs[19] = mk(32'h0000_3003, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, 0, 0);
    vecs[20] = mk(32'h0000_3000, 1, 1, 32'h3050,     0, 0, 32'h0,        32'h0000_3000, 0, 0, 0, 0);
    vecs[21] = mk(32'h0000_3000, 1, 0, 32'h0,        0, 1, 32'h3020,     32'h0000_3020, 1, 1, 1, 0);
    vecs[22] = mk(32'h0000_3020, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3024, 1, 0, 0, 0);

    // Held in reset: outputs pinned to the reset values.
    reset = 1'b0;
    drive(32'h0000_3000, 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check_outs("in_reset", 32'h0000_3000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pc, vecs[i].stall, vecs[i].rv, vecs[i].rt,
            vecs[i].exc, vecs[i].eret, vecs[i].epc);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vecs[i].e_npc, vecs[i].e_en, vecs[i].e_fl,
                 vecs[i].e_pend, vecs[i].e_mis);
      @(posedge clk);
      #1;
    end

    // Async reset while a redirect is buffered.
    drive(32'h0000_3024, 1, 1, 32'h0000_3200, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    drive(32'h0000_3024, 1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check_outs("pend_before_rst", 32'h0000_3024, 0, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", 32'h0000_3000, 0, 0, 0, 0);
    bus.exc_req = 1'b1;
    #1;
    check_outs("rst_exc", 32'h0000_3000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(32'h0000_3000, 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outs("post_rst", 32'h0000_3004, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(32'h0000_3004, 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check_outs("no_stale", 32'h0000_3008, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
